// File: rtl/obi_data_arbiter_pkg.sv
// obi_data_arbiter_pkg: shared types and helpers for the OBI data arbiter.
// Holds the index-width helper, the default request bundle and FIFO depth.
package obi_data_arbiter_pkg;

  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;

  typedef struct packed {
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_ADDR_W-1:0]   addr;
    logic [OBI_DATA_W-1:0]   wdata;
  } obi_req_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/obi_data_arbiter_src_fifo.sv
// obi_data_arbiter_src_fifo: tracks the source master of each outstanding
// transaction. Ports: clk_i, rst_ni, push_i/data_i, pop_i/data_o,
// full_o, empty_o, count_o (occupancy, 0..DEPTH).
module obi_data_arbiter_src_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_i) begin
        mem[wptr] <= data_i;
        wptr      <= wptr + 1'b1;
      end
      if (pop_i) rptr <= rptr + 1'b1;
      if (push_i && !pop_i) cnt <= cnt + 1'b1;
      else if (!push_i && pop_i) cnt <= cnt - 1'b1;
    end
  end

  assign data_o  = mem[rptr];
  assign full_o  = (cnt == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt == '0);
  assign count_o = cnt;

endmodule

// File: rtl/obi_data_arbiter.sv
// obi_data_arbiter: N-master to 1-slave OBI data arbiter, in-order responses.
// Ports: m_* master side (req/gnt/we/be/addr/wdata/rvalid/rdata), s_* slave
// side, outstanding_o occupancy, spurious_rsp_o sticky orphan-response flag.
// Macro OBI_DATA_ARBITER_RR_EN selects round-robin instead of fixed priority.
module obi_data_arbiter
  import obi_data_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int RSP_REG         = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_be_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [DATA_W-1:0]                 m_rdata_o,
  output logic                              s_req_o,
  input  logic                              s_gnt_i,
  output logic                              s_we_o,
  output logic [DATA_W/8-1:0]               s_be_o,
  output logic [ADDR_W-1:0]                 s_addr_o,
  output logic [DATA_W-1:0]                 s_wdata_o,
  input  logic                              s_rvalid_i,
  input  logic [DATA_W-1:0]                 s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
  output logic                              spurious_rsp_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = idx_w(NUM_MASTERS);

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [IDX_W-1:0]  arb_win;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  lock_idx_q;
  logic [IDX_W-1:0]  head;
  logic              lock_q;
  logic              any_req;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              stall;
  logic              dvalid;
  logic [DATA_W-1:0] drdata;
  logic              spur_q;
  req_t              sel;

`ifdef OBI_DATA_ARBITER_RR_EN
  logic [IDX_W-1:0] rr_q;

  always_comb begin : arb
    int  j;
    logic found;
    arb_win = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = (int'(rr_q) + i) % NUM_MASTERS;
      if (!found && m_req_i[j[IDX_W-1:0]]) begin
        found   = 1'b1;
        arb_win = j[IDX_W-1:0];
      end
    end
  end

  // Next search starts just past the master that was accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else if (push)
      rr_q <= (int'(win) == NUM_MASTERS - 1) ? '0 : win + 1'b1;
  end
`else
  always_comb begin : arb
    arb_win = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (m_req_i[IDX_W'(i)]) arb_win = IDX_W'(i);
  end
`endif

  // A presented but ungranted request keeps ownership of the slave port.
  assign any_req = lock_q | (|m_req_i);
  assign win     = lock_q ? lock_idx_q : arb_win;
  assign stall   = full & ~pop;
  assign s_req_o = any_req & ~stall;
  assign push    = s_req_o & s_gnt_i;
  assign pop     = dvalid & ~empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (s_req_o && !s_gnt_i) begin
      lock_q     <= 1'b1;
      lock_idx_q <= win;
    end else if (s_req_o) begin
      lock_q     <= 1'b0;
    end
  end

  always_comb begin
    sel = '0;
    if (s_req_o) begin
      sel.we    = m_we_i[win];
      sel.be    = m_be_i[win*BE_W +: BE_W];
      sel.addr  = m_addr_i[win*ADDR_W +: ADDR_W];
      sel.wdata = m_wdata_i[win*DATA_W +: DATA_W];
    end
  end

  assign s_we_o    = sel.we;
  assign s_be_o    = sel.be;
  assign s_addr_o  = sel.addr;
  assign s_wdata_o = sel.wdata;

  always_comb begin
    m_gnt_o = '0;
    if (push) m_gnt_o[win] = 1'b1;
  end

  obi_data_arbiter_src_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDX_W)
  ) u_src_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (win),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o)
  );

  if (RSP_REG != 0) begin : g_rsp_reg
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= s_rvalid_i;
        rdata_q  <= s_rdata_i;
      end
    end

    assign dvalid = rvalid_q;
    assign drdata = rdata_q;
  end else begin : g_rsp_comb
    assign dvalid = s_rvalid_i;
    assign drdata = s_rdata_i;
  end

  always_comb begin
    m_rvalid_o = '0;
    if (pop) m_rvalid_o[head] = 1'b1;
  end

  assign m_rdata_o = drdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) spur_q <= 1'b0;
    else if (dvalid && empty) spur_q <= 1'b1;
  end

  assign spurious_rsp_o = spur_q;

endmodule

// File: doc/obi_data_arbiter.md
Name: obi_data_arbiter

Overview:
N-master to 1-slave OBI data-bus arbiter with in-order response routing. It is the parametrised successor to the fixed CPU/RTOSUnit data-bus sharing in the simulation wrappers, and sits between the core, the RTOSUnit context-memory port and any further masters on one side, and the shared data memory on the other. Unlike that sharing, it honours slave grant for every master and locks the winner until granted. It tracks outstanding transactions in a FIFO of configurable depth and stalls when that FIFO is full. It also flags spurious responses.

Parameters:
NUM_MASTERS, 2, number of requesting masters (>=1); index 0 = CPU.
MAX_OUTSTANDING, 4, depth of the source-tracking FIFO (power of 2, >=2).
ADDR_W, 32, address width.
DATA_W, 32, data width; BE_W = DATA_W/8.
RSP_REG, 1, 1 = register slave rvalid/rdata one cycle before routing; 0 = combinational pass-through.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m_req_i  in  NUM_MASTERS  per-master request
m_gnt_o  out  NUM_MASTERS  per-master grant
m_we_i  in  NUM_MASTERS  per-master write enable
m_be_i  in  NUM_MASTERS*BE_W  byte enables, master k at slice k
m_addr_i  in  NUM_MASTERS*ADDR_W  addresses
m_wdata_i  in  NUM_MASTERS*DATA_W  write data
m_rvalid_o  out  NUM_MASTERS  per-master response valid
m_rdata_o  out  DATA_W  response data, broadcast to all masters
s_req_o  out  1  slave request
s_gnt_i  in  1  slave grant
s_we_o  out  1  slave write enable
s_be_o  out  BE_W  slave byte enables
s_addr_o  out  ADDR_W  slave address
s_wdata_o  out  DATA_W  slave write data
s_rvalid_i  in  1  slave response valid
s_rdata_i  in  DATA_W  slave response data
outstanding_o  out  clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
spurious_rsp_o  out  1  sticky flag: response arrived with no outstanding request

Behaviour:
- Reset (async assert, sync deassert assumed upstream): FIFO pointers/count 0, lock cleared, registered rvalid 0, rdata 0, spurious_rsp_o 0, RR pointer 0. Outputs at reset: s_req_o 0, m_gnt_o 0, m_rvalid_o 0, outstanding_o 0.
- Address phase is combinational from m_req_i to s_req_o/s_* (0-cycle latency). s_* carry the winner's signals, or all-zero when idle.
- stall = full && !pop. While stalled: s_req_o = 0 and m_gnt_o = 0.
- Winner selection: fixed priority, lowest index wins. Exception: the lock.
- Lock: when s_req_o && !s_gnt_i, the winner index is registered. The next cycle reuses it regardless of other requests, until s_gnt_i. This keeps OBI address-phase signals stable.
- m_gnt_o[w] = s_gnt_i && s_req_o. All other grant bits are 0.
- Push on s_req_o && s_gnt_i: writes the winner index (reads and writes alike; OBI responds to both).
- Pop on response delivery: RSP_REG=1 on registered rvalid; RSP_REG=0 on s_rvalid_i. The pop only happens if count>0.
- m_rvalid_o[head] = delivered rvalid && count>0. m_rdata_o = delivered rdata. Response latency from slave to master is RSP_REG cycles.
- Simultaneous push+pop: count unchanged; allowed even when full.
- Spurious response (delivered rvalid with count==0): no m_rvalid_o. spurious_rsp_o is set and stays set until reset. Pointers are not disturbed.
- Pointer wrap modulo MAX_OUTSTANDING; count saturates by construction (never pushes when full without a pop).
- Reset mid-transaction: tracking is lost. Late slave responses count as spurious.

Optional Feature:
OBI_DATA_ARBITER_RR_EN. Defined: round-robin arbitration. After a grant to master k, priority starts at k+1 mod NUM_MASTERS. The RR pointer updates only on an accepted handshake (s_req_o && s_gnt_i). Lock semantics are unchanged. Undefined: fixed priority as above, and no RR pointer register.

Decomposition:
- Package obi_data_arbiter_pkg: function for index width (max(1, clog2(NUM_MASTERS))); typedef for the OBI request struct {we, be, addr, wdata}; constant for the default MAX_OUTSTANDING.
- Sub-module obi_data_arbiter_src_fifo: a MAX_OUTSTANDING-deep, index-wide FIFO with push/pop/full/empty/count.

Test Plan:
1. N=2, RSP_REG=1: master 0 reads 0x100, s_gnt_i=1, s_rvalid_i the next cycle with 0xDEADBEEF -> m_rvalid_o=2'b01 one cycle later, m_rdata_o=0xDEADBEEF, outstanding_o returns to 0.
2. Masters 0 and 1 request in the same cycle, gnt always 1 -> master 0 granted at cycle 0, master 1 at cycle 1. Responses A, B route to m_rvalid_o[0] then m_rvalid_o[1].
3. Master 1 requests 0x200, s_gnt_i low for 3 cycles, master 0 raises req at cycle 1 -> s_addr_o holds 0x200 until the gnt cycle, then master 0 is served.
4. Four granted requests, no responses -> outstanding_o=4, a fifth request sees s_req_o=0 and m_gnt_o=0. A response delivered in a later cycle -> the fifth is granted that cycle and outstanding_o stays 4.
5. s_rvalid_i pulse with outstanding_o=0 -> m_rvalid_o=0, spurious_rsp_o=1 held through 10 further idle cycles, cleared only by rst_ni=0.
6. With OBI_DATA_ARBITER_RR_EN, both masters requesting continuously, gnt=1 -> grant sequence 0,1,0,1. Without the macro -> 0,0,0,0.
